conversor_bcd_sequencial: RTL and testbench

Sequential binary-to-BCD converter for the 9-bit sum and difference results of the 8-bit adder/subtractor. It converts one result per request and drives three 7-segment digits plus a sign flag. It sits on the display side of the arithmetic block, so the bench and board can read decimal values instead of binary vectors. Conversion is shift-and-add-3 (double dabble), one bit per clock.

---
 rtl/conversor_bcd_sequencial_pkg.sv | 52 +++++
 rtl/conversor_bcd_sequencial_if.sv | 27 ++
 rtl/conversor_bcd_sequencial_7seg.sv | 26 ++
 rtl/conversor_bcd_sequencial.sv | 108 ++++++++++
 tb/tb_conversor_bcd_sequencial.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/conversor_bcd_sequencial_pkg.sv
// Shared types, widths and constants for the sequential binary-to-BCD converter.
// Covers FSM encoding, shift count, 7-segment patterns and the BCD adjust helper.
package conversor_bcd_sequencial_pkg;

  localparam int unsigned VALOR_W   = 9;
  localparam int unsigned DIGITO_W  = 4;
  localparam int unsigned N_DIGITOS = 3;
  localparam int unsigned BCD_W     = N_DIGITOS * DIGITO_W;
  localparam int unsigned SEG_W     = 7;
  localparam int unsigned CONT_W    = 4;

  localparam logic [CONT_W-1:0] N_DESLOCA = CONT_W'(9);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    DESLOCA = 2'd1,
    FIM     = 2'd2
  } estado_t;

  // Last published result; held until the next FIM
  typedef struct packed {
    logic                negativo;
    logic [DIGITO_W-1:0] centena;
    logic [DIGITO_W-1:0] dezena;
    logic [DIGITO_W-1:0] unidade;
  } resultado_t;

  // Segment order is {g,f,e,d,c,b,a}, active-high
  localparam logic [SEG_W-1:0] SEG_0       = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1       = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2       = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3       = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4       = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5       = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6       = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7       = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8       = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9       = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_APAGADO = 7'b0000000;

  // Double-dabble correction: add 3 to every nibble that is 5 or more
  function automatic logic [BCD_W-1:0] ajusta_bcd(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < int'(N_DIGITOS); i++) begin
      if (bcd[i*DIGITO_W +: DIGITO_W] >= DIGITO_W'(5))
        r[i*DIGITO_W +: DIGITO_W] = bcd[i*DIGITO_W +: DIGITO_W] + DIGITO_W'(3);
    end
    return r;
  endfunction

endpackage

// File: rtl/conversor_bcd_sequencial_if.sv
// Request/result bundle between a requester and the BCD converter.
interface conversor_bcd_sequencial_if;
  import conversor_bcd_sequencial_pkg::*;

  logic                inicio;
  logic [VALOR_W-1:0]  valor;
  logic                ocupado;
  logic                pronto;
  logic                negativo;
  logic [DIGITO_W-1:0] centena;
  logic [DIGITO_W-1:0] dezena;
  logic [DIGITO_W-1:0] unidade;
  logic [SEG_W-1:0]    seg_c;
  logic [SEG_W-1:0]    seg_d;
  logic [SEG_W-1:0]    seg_u;

  modport master (
    output inicio, valor,
    input  ocupado, pronto, negativo, centena, dezena, unidade, seg_c, seg_d, seg_u
  );

  modport slave (
    input  inicio, valor,
    output ocupado, pronto, negativo, centena, dezena, unidade, seg_c, seg_d, seg_u
  );

endinterface

// File: rtl/conversor_bcd_sequencial_7seg.sv
// Combinational BCD digit to 7-segment decoder; codes 10..15 blank the display.
module decodificador_7seg
  import conversor_bcd_sequencial_pkg::*;
(
  input  logic [DIGITO_W-1:0] digito,
  output logic [SEG_W-1:0]    segmentos_c
);

  always_comb begin
    segmentos_c = SEG_APAGADO;
    case (digito)
      4'd0:    segmentos_c = SEG_0;
      4'd1:    segmentos_c = SEG_1;
      4'd2:    segmentos_c = SEG_2;
      4'd3:    segmentos_c = SEG_3;
      4'd4:    segmentos_c = SEG_4;
      4'd5:    segmentos_c = SEG_5;
      4'd6:    segmentos_c = SEG_6;
      4'd7:    segmentos_c = SEG_7;
      4'd8:    segmentos_c = SEG_8;
      4'd9:    segmentos_c = SEG_9;
      default: segmentos_c = SEG_APAGADO;
    endcase
  end

endmodule

// File: rtl/conversor_bcd_sequencial.sv
// Sequential double-dabble converter: one 9-bit value per request, one bit per clock,
// driving three BCD digits, their 7-segment decodes and a sign flag.
module conversor_bcd_sequencial
  import conversor_bcd_sequencial_pkg::*;
#(
  parameter bit COM_SINAL = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  conversor_bcd_sequencial_if.slave     bus
);

  estado_t            estado, estado_n;
  logic               sinal_r, sinal_n;
  logic [VALOR_W-1:0] mag_r, mag_n;
  logic [BCD_W-1:0]   bcd_r, bcd_n;
  logic [CONT_W-1:0]  cont_r, cont_n;
  resultado_t         res_r, res_n;
  logic               pronto_r, pronto_n;
  logic               ocupado_r, ocupado_n;

  logic               sinal_ent;
  logic [VALOR_W-1:0] mag_ent;
  logic [BCD_W-1:0]   bcd_ajustado;

  // Sign and magnitude of the incoming value; 9'h100 reads back as 256
  assign sinal_ent    = COM_SINAL ? bus.valor[VALOR_W-1] : 1'b0;
  assign mag_ent      = sinal_ent ? VALOR_W'(~bus.valor + VALOR_W'(1)) : bus.valor;
  assign bcd_ajustado = ajusta_bcd(bcd_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= OCIOSO;
      sinal_r   <= 1'b0;
      mag_r     <= '0;
      bcd_r     <= '0;
      cont_r    <= '0;
      res_r     <= '0;
      pronto_r  <= 1'b0;
      ocupado_r <= 1'b0;
    end else begin
      estado    <= estado_n;
      sinal_r   <= sinal_n;
      mag_r     <= mag_n;
      bcd_r     <= bcd_n;
      cont_r    <= cont_n;
      res_r     <= res_n;
      pronto_r  <= pronto_n;
      ocupado_r <= ocupado_n;
    end
  end

  always_comb begin
    estado_n  = estado;
    sinal_n   = sinal_r;
    mag_n     = mag_r;
    bcd_n     = bcd_r;
    cont_n    = cont_r;
    res_n     = res_r;
    pronto_n  = 1'b0;
    ocupado_n = ocupado_r;

    case (estado)
      OCIOSO: begin
        if (bus.inicio) begin
          estado_n  = DESLOCA;
          sinal_n   = sinal_ent;
          mag_n     = mag_ent;
          bcd_n     = '0;
          cont_n    = N_DESLOCA;
          ocupado_n = 1'b1;
        end
      end
      DESLOCA: begin
        // Top bit of the adjusted accumulator falls off: centena never exceeds 5
        {bcd_n, mag_n} = {bcd_ajustado, mag_r} << 1;
        cont_n         = cont_r - CONT_W'(1);
        if (cont_r == CONT_W'(1))
          estado_n = FIM;
      end
      FIM: begin
        res_n.negativo = sinal_r;
        res_n.centena  = bcd_r[2*DIGITO_W +: DIGITO_W];
        res_n.dezena   = bcd_r[DIGITO_W +: DIGITO_W];
        res_n.unidade  = bcd_r[0 +: DIGITO_W];
        pronto_n       = 1'b1;
        ocupado_n      = 1'b0;
        estado_n       = OCIOSO;
      end
      default: begin
        estado_n  = OCIOSO;
        ocupado_n = 1'b0;
      end
    endcase
  end

  assign bus.ocupado  = ocupado_r;
  assign bus.pronto   = pronto_r;
  assign bus.negativo = res_r.negativo;
  assign bus.centena  = res_r.centena;
  assign bus.dezena   = res_r.dezena;
  assign bus.unidade  = res_r.unidade;

  decodificador_7seg u_dec_c (.digito(res_r.centena), .segmentos_c(bus.seg_c));
  decodificador_7seg u_dec_d (.digito(res_r.dezena),  .segmentos_c(bus.seg_d));
  decodificador_7seg u_dec_u (.digito(res_r.unidade), .segmentos_c(bus.seg_u));

endmodule

// File: tb/tb_conversor_bcd_sequencial.sv
// Bench for conversor_bcd_sequencial: an unsigned and a signed instance side by side,
// table vectors, hand-written busy/reset sequences and random values against a decimal model.
module tb_conversor_bcd_sequencial;

  logic clk;
  logic rst_n;

  conversor_bcd_sequencial_if if_u ();
  conversor_bcd_sequencial_if if_s ();

  conversor_bcd_sequencial #(.COM_SINAL(1'b0)) dut_u (.clk(clk), .rst_n(rst_n), .bus(if_u));
  conversor_bcd_sequencial #(.COM_SINAL(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] seg_tab [10];

  typedef struct {
    bit         ocupado;
    bit         pronto;
    bit         negativo;
    int         c;
    int         d;
    int         u;
    logic [6:0] sc;
    logic [6:0] sd;
    logic [6:0] su;
  } obs_t;

  typedef struct {
    bit         sinal;
    logic [8:0] valor;
    bit         neg;
    int         c;
    int         d;
    int         u;
  } vetor_t;

  vetor_t tabela [8];

  function automatic obs_t le(input bit s);
    obs_t o;
    if (s) begin
      o.ocupado = if_s.ocupado;  o.pronto = if_s.pronto;  o.negativo = if_s.negativo;
      o.c = int'(if_s.centena);  o.d = int'(if_s.dezena);  o.u = int'(if_s.unidade);
      o.sc = if_s.seg_c;         o.sd = if_s.seg_d;        o.su = if_s.seg_u;
    end else begin
      o.ocupado = if_u.ocupado;  o.pronto = if_u.pronto;  o.negativo = if_u.negativo;
      o.c = int'(if_u.centena);  o.d = int'(if_u.dezena);  o.u = int'(if_u.unidade);
      o.sc = if_u.seg_c;         o.sd = if_u.seg_d;        o.su = if_u.seg_u;
    end
    return o;
  endfunction

  // Decimal reference: interpret the value, then split its magnitude into digits
  task automatic modelo(input bit s, input logic [8:0] v,
                        output bit neg, output int c, output int d, output int u);
    int x;
    int m;
    x = int'(v);
    if (s && v[8]) x = x - 512;
    neg = (x < 0);
    m   = neg ? -x : x;
    c   = m / 100;
    d   = (m / 10) % 10;
    u   = m % 10;
  endtask

  task automatic chk(input string nome, input int atual, input int esperado);
    n_cmp++;
    if (atual != esperado) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  task automatic poe_inicio(input bit s, input bit ini, input logic [8:0] v);
    if (s) begin if_s.inicio = ini; if_s.valor = v; end
    else   begin if_u.inicio = ini; if_u.valor = v; end
  endtask

  task automatic chk_resultado(input string tag, input obs_t o,
                               input bit neg, input int c, input int d, input int u);
    chk({tag, "_negativo"}, int'(o.negativo), int'(neg));
    chk({tag, "_centena"}, o.c, c);
    chk({tag, "_dezena"},  o.d, d);
    chk({tag, "_unidade"}, o.u, u);
    chk({tag, "_seg_c"}, int'(o.sc), int'(seg_tab[c]));
    chk({tag, "_seg_d"}, int'(o.sd), int'(seg_tab[d]));
    chk({tag, "_seg_u"}, int'(o.su), int'(seg_tab[u]));
  endtask

  // One full conversion: accept, check latency, result and single-cycle pronto
  task automatic converte(input string tag, input bit s, input logic [8:0] v,
                          input bit neg, input int c, input int d, input int u);
    obs_t o;
    int   n;
    @(negedge clk);
    poe_inicio(s, 1'b1, v);
    @(negedge clk);
    poe_inicio(s, 1'b0, 9'($urandom));
    o = le(s);
    chk({tag, "_ocupado_E0"}, int'(o.ocupado), 1);
    n = 0;
    while (!o.pronto && n < 20) begin
      @(negedge clk);
      n++;
      o = le(s);
    end
    chk({tag, "_latencia"}, n, 10);
    chk({tag, "_ocupado_E10"}, int'(o.ocupado), 0);
    chk_resultado(tag, o, neg, c, d, u);
    @(negedge clk);
    o = le(s);
    chk({tag, "_pronto_E11"}, int'(o.pronto), 0);
  endtask

  initial begin
    obs_t o;
    bit   neg;
    int   c, d, u, n, cnt_p, cnt_o;
    logic [8:0] v;

    seg_tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    tabela[0] = '{1'b0, 9'd10,   1'b0, 0, 1, 0};
    tabela[1] = '{1'b0, 9'd510,  1'b0, 5, 1, 0};
    tabela[2] = '{1'b1, 9'h1CE,  1'b1, 0, 5, 0};
    tabela[3] = '{1'b1, 9'h100,  1'b1, 2, 5, 6};
    tabela[4] = '{1'b0, 9'd511,  1'b0, 5, 1, 1};
    tabela[5] = '{1'b0, 9'd0,    1'b0, 0, 0, 0};
    tabela[6] = '{1'b1, 9'h0FF,  1'b0, 2, 5, 5};
    tabela[7] = '{1'b1, 9'h1FF,  1'b1, 0, 0, 1};

    rst_n = 1'b0;
    poe_inicio(1'b0, 1'b0, 9'd0);
    poe_inicio(1'b1, 1'b0, 9'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int s = 0; s < 2; s++) begin
      o = le(s[0]);
      chk("reset_ocupado", int'(o.ocupado), 0);
      chk("reset_pronto",  int'(o.pronto), 0);
      chk_resultado("reset", o, 1'b0, 0, 0, 0);
    end

    for (int i = 0; i < 8; i++)
      converte($sformatf("tab%0d", i), tabela[i].sinal, tabela[i].valor,
               tabela[i].neg, tabela[i].c, tabela[i].d, tabela[i].u);

    // Start ignored while busy: second request sampled at E4 must be dropped
    @(negedge clk);
    poe_inicio(1'b0, 1'b1, 9'd15);
    @(negedge clk);
    poe_inicio(1'b0, 1'b0, 9'd0);
    repeat (3) @(negedge clk);
    poe_inicio(1'b0, 1'b1, 9'd200);
    @(negedge clk);
    poe_inicio(1'b0, 1'b0, 9'd200);
    n = 4;
    o = le(1'b0);
    while (!o.pronto && n < 20) begin
      @(negedge clk);
      n++;
      o = le(1'b0);
    end
    chk("ocupado_ign_latencia", n, 10);
    chk_resultado("ocupado_ign", o, 1'b0, 0, 1, 5);
    cnt_p = 0;
    cnt_o = 0;
    repeat (12) begin
      @(negedge clk);
      o = le(1'b0);
      if (o.pronto)  cnt_p++;
      if (o.ocupado) cnt_o++;
    end
    chk("ocupado_ign_sem_pronto", cnt_p, 0);
    chk("ocupado_ign_sem_ocupado", cnt_o, 0);

    // Reset mid-conversion at E5 on both instances
    @(negedge clk);
    poe_inicio(1'b0, 1'b1, 9'd300);
    poe_inicio(1'b1, 1'b1, 9'h1CE);
    @(negedge clk);
    poe_inicio(1'b0, 1'b0, 9'd0);
    poe_inicio(1'b1, 1'b0, 9'd0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      o = le(s[0]);
      chk("rst_meio_ocupado", int'(o.ocupado), 0);
      chk("rst_meio_pronto",  int'(o.pronto), 0);
      chk_resultado("rst_meio", o, 1'b0, 0, 0, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cnt_p = 0;
    repeat (15) begin
      @(negedge clk);
      if (if_u.pronto) cnt_p++;
      if (if_s.pronto) cnt_p++;
    end
    chk("rst_meio_sem_pronto", cnt_p, 0);

    for (int i = 0; i < 24; i++) begin
      v = 9'($urandom_range(0, 511));
      modelo(i[0], v, neg, c, d, u);
      converte($sformatf("rnd%0d_%0d", i, v), i[0], v, neg, c, d, u);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
